operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port wr_en, input, 1 bit: register-file write enable.
REQ-004 The block SHALL have port wr_num, input, 3 bits: register-file write index.
REQ-005 The block SHALL have port wr_data, input, 16 bits: register-file write data.
REQ-006 The block SHALL have port req_valid, input, 1 bit: operand-fetch request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-008 The block SHALL have port rd_a, input, 3 bits: register index of operand A, sampled on accept.
REQ-009 The block SHALL have port rd_b, input, 3 bits: register index of operand B, sampled on accept.
REQ-010 The block SHALL have port shift_in, input, 2 bits: shift code, sampled on accept.
REQ-011 The block SHALL have port op_valid, output, 1 bit: a_out, b_out and shift_out are valid.
REQ-012 The block SHALL have port op_ready, input, 1 bit: downstream shifter/ALU stage consumes the operands.
REQ-013 The block SHALL have port a_out, output, 16 bits: operand A, fed to the ALU.
REQ-014 The block SHALL have port b_out, output, 16 bits: operand B, fed to the shifter data input.
REQ-015 The block SHALL have port shift_out, output, 2 bits: shift code for the shifter (0 pass, 1 left by 1 with 0 fill, 2 logical right by 1, 3 arithmetic right by 1).

Function
REQ-016 The block SHALL contain 8 x 16-bit registers R0-R7 with one write port and one read port.
REQ-017 On a rising edge with wr_en=1, the block SHALL write wr_data to R[wr_num], in any FSM state.
REQ-018 The FSM SHALL have the states IDLE, READ_A, READ_B and HOLD.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted at an edge where the FSM is in IDLE and req_valid=1; at that edge the block SHALL latch rd_a, rd_b and shift_in and go to READ_A.
REQ-021 In READ_A, the block SHALL latch R[rd_a] into a_out at the next edge and go to READ_B.
REQ-022 In READ_B, the block SHALL latch R[rd_b] into b_out and the latched shift code into shift_out at the next edge and go to HOLD.
REQ-023 op_valid SHALL be 1 only in HOLD; it SHALL rise 2 edges after the accept edge.
REQ-024 In HOLD with op_ready=1, the block SHALL go to IDLE at the edge; op_valid SHALL fall and req_ready SHALL rise in the next cycle.
REQ-025 In HOLD with op_ready=0, the block SHALL hold a_out, b_out and shift_out stable, whatever wr_en, req_valid or rd_* do.
REQ-026 op_ready SHALL be ignored outside HOLD; req_valid SHALL be ignored outside IDLE.
REQ-027 Read/write collision: a read in the same cycle as a write to the same register SHALL return the pre-write value; the new value SHALL be visible from the following cycle.
REQ-028 rd_a equal to rd_b SHALL be legal and SHALL yield a_out = b_out.
REQ-029 a_out, b_out and shift_out SHALL change only at READ_A/READ_B edges and SHALL be 16/16/2 bits with no sign extension or truncation.

Reset
REQ-030 On an edge with reset_n=0, the block SHALL clear R0-R7 to 0, enter IDLE, and clear a_out, b_out and shift_out to 0.
REQ-031 During reset, op_valid SHALL be 0 and req_ready SHALL be 1 from the first post-reset cycle.
REQ-032 Reset SHALL take priority over wr_en and over any in-flight request; a reset in READ_A, READ_B or HOLD SHALL abort the request with no op_valid pulse.

Verification
REQ-033 The bench SHALL cover: write R3=16'b1011101010110111, then request rd_a=3, rd_b=3, shift_in=1 -> op_valid rises 2 edges after accept, a_out=b_out=16'b1011101010110111, shift_out=1.
REQ-034 The bench SHALL cover: R5=16'b1111000011001111, R2=16'hFFFF, request rd_a=2, rd_b=5, shift_in=3, op_ready held 0 for 4 cycles with writes to R5 meanwhile -> outputs stay 16'hFFFF / 16'b1111000011001111 / 3 until op_ready=1, then IDLE with req_ready=1 next cycle.
REQ-035 The bench SHALL cover: write R4=16'h1234 in the same cycle as the READ_B read of R4 (old value 0) -> b_out=16'h0000; the next request yields 16'h1234.
REQ-036 The bench SHALL cover: reset_n=0 asserted in READ_B -> op_valid never asserts, a_out=b_out=0, all registers read back 0, and req_ready=1 after release.
REQ-037 The bench SHALL cover: req_valid held high continuously with op_ready=1 -> one accept every 4 cycles, op_valid high for exactly 1 cycle per request.
REQ-038 The bench SHALL cover: feed b_out/shift_out to the existing shifter with codes 0-3 on 16'b1111111111111111 -> shifter outputs 16'hFFFF, 16'hFFFE, 16'h7FFF, 16'hFFFF.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: 8x16 register file with a four-state operand fetch FSM feeding the shifter/ALU stage
// Ports: clk, reset_n (sync, active-low); wr_en/wr_num/wr_data register write port;
//        req_valid/req_ready + rd_a/rd_b/shift_in request handshake;
//        op_valid/op_ready + a_out/b_out/shift_out operand handshake
module operand_fetch (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [2:0]  wr_num,
   input  logic [15:0] wr_data,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  rd_a,
   input  logic [2:0]  rd_b,
   input  logic [1:0]  shift_in,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [15:0] a_out,
   output logic [15:0] b_out,
   output logic [1:0]  shift_out
);
   typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;
   state_t      state_q, state_d;
   logic [15:0] rf_q [8];
   logic [15:0] rf_d [8];
   logic [2:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
   logic [1:0]  sh_q, sh_d, shift_q, shift_d;
   logic [15:0] a_q, a_d, b_q, b_d, rd_data;
   // Single read port: READ_A reads operand A, otherwise operand B. Reading rf_q
   // gives the pre-write value when a write to the same register lands this edge.
   always_comb begin
      state_d = state_q;
      rf_d    = rf_q;
      rd_a_d  = rd_a_q;
      rd_b_d  = rd_b_q;
      sh_d    = sh_q;
      a_d     = a_q;
      b_d     = b_q;
      shift_d = shift_q;
      rd_data = rf_q[state_q == READ_A ? rd_a_q : rd_b_q];
      if (wr_en) rf_d[wr_num] = wr_data;
      case (state_q)
         IDLE: if (req_valid) begin
            rd_a_d  = rd_a;
            rd_b_d  = rd_b;
            sh_d    = shift_in;
            state_d = READ_A;
         end
         READ_A: begin
            a_d     = rd_data;
            state_d = READ_B;
         end
         READ_B: begin
            b_d     = rd_data;
            shift_d = sh_q;
            state_d = HOLD;
         end
         HOLD: state_d = op_ready ? IDLE : HOLD;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rf_q    <= '{default: '0};
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         sh_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         rf_q    <= rf_d;
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         sh_q    <= sh_d;
         a_q     <= a_d;
         b_q     <= b_d;
         shift_q <= shift_d;
      end
   end
   // op_valid is gated by reset_n so no pulse escapes while reset is held.
   assign req_ready = state_q == IDLE;
   assign op_valid  = state_q == HOLD && reset_n;
   assign a_out     = a_q;
   assign b_out     = b_q;
   assign shift_out = shift_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed table-driven bench for operand_fetch
module tb_operand_fetch;
   logic        clk = 0, reset_n = 0, wr_en = 0, req_valid = 0, op_ready = 0;
   logic [2:0]  wr_num = 0, rd_a = 0, rd_b = 0;
   logic [15:0] wr_data = 0;
   logic [1:0]  shift_in = 0;
   logic        req_ready, op_valid;
   logic [15:0] a_out, b_out;
   logic [1:0]  shift_out;
   int errors = 0, checks = 0;

   operand_fetch dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
      .req_valid(req_valid), .req_ready(req_ready), .rd_a(rd_a), .rd_b(rd_b),
      .shift_in(shift_in), .op_valid(op_valid), .op_ready(op_ready),
      .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  a;
      logic [2:0]  b;
      logic [1:0]  sh;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] n, input logic [15:0] d);
      wr_en = 1; wr_num = n; wr_data = d;
      tick();
      wr_en = 0;
   endtask

   function automatic logic [15:0] shifter(input logic [15:0] d, input logic [1:0] c);
      return c == 0 ? d : c == 1 ? {d[14:0], 1'b0} : c == 2 ? {1'b0, d[15:1]} : {d[15], d[15:1]};
   endfunction

   // Accepts a request and waits (bounded) for op_valid; leaves the FSM in HOLD.
   task automatic start_req(input string name, input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh);
      int n = 0;
      chk({name, " req_ready"}, 16'(req_ready), 16'd1);
      req_valid = 1; rd_a = a; rd_b = b; shift_in = sh;
      tick();
      req_valid = 0;
      while (!op_valid && n < 8) begin
         tick();
         n++;
      end
      chk({name, " latency"}, 16'(n), 16'd2);
   endtask

   task automatic finish_req(input string name);
      op_ready = 1;
      tick();
      op_ready = 0;
      chk({name, " op_valid low"}, 16'(op_valid), 16'd0);
      chk({name, " req_ready back"}, 16'(req_ready), 16'd1);
   endtask

   task automatic do_req(input string name, input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                         input logic [15:0] ea, input logic [15:0] eb);
      start_req(name, a, b, sh);
      chk({name, " a_out"}, a_out, ea);
      chk({name, " b_out"}, b_out, eb);
      chk({name, " shift_out"}, 16'(shift_out), 16'(sh));
      finish_req(name);
   endtask

   initial begin
      vec_t vt [6];
      logic [15:0] init [8];
      logic [15:0] sexp [4];
      int acc, ov, bad;
      init = '{16'h0001, 16'h8000, 16'hFFFF, 16'hBAB7, 16'h1234, 16'hF0CF, 16'h00FF, 16'h7FFE};
      vt[0] = '{3'd0, 3'd1, 2'd0, 16'h0001, 16'h8000};
      vt[1] = '{3'd7, 3'd6, 2'd1, 16'h7FFE, 16'h00FF};
      vt[2] = '{3'd2, 3'd4, 2'd2, 16'hFFFF, 16'h1234};
      vt[3] = '{3'd5, 3'd3, 2'd3, 16'hF0CF, 16'hBAB7};
      vt[4] = '{3'd1, 3'd1, 2'd2, 16'h8000, 16'h8000};
      vt[5] = '{3'd6, 3'd0, 2'd1, 16'h00FF, 16'h0001};
      sexp = '{16'hFFFF, 16'hFFFE, 16'h7FFF, 16'hFFFF};

      // Reset state
      tick();
      chk("reset op_valid", 16'(op_valid), 16'd0);
      tick();
      reset_n = 1;
      chk("reset req_ready", 16'(req_ready), 16'd1);
      chk("reset a_out", a_out, 16'h0);
      chk("reset b_out", b_out, 16'h0);
      chk("reset shift_out", 16'(shift_out), 16'h0);

      // Table-driven reads
      for (int i = 0; i < 8; i++) wr(3'(i), init[i]);
      for (int i = 0; i < 6; i++)
         do_req($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sh, vt[i].ea, vt[i].eb);

      // rd_a == rd_b on R3 with left shift
      wr(3'd3, 16'b1011101010110111);
      do_req("same_reg", 3'd3, 3'd3, 2'd1, 16'b1011101010110111, 16'b1011101010110111);

      // Stall in HOLD while writes and request inputs churn
      wr(3'd5, 16'b1111000011001111);
      wr(3'd2, 16'hFFFF);
      start_req("stall", 3'd2, 3'd5, 2'd3);
      for (int i = 0; i < 4; i++) begin
         wr_en = 1; wr_num = 3'd5; wr_data = 16'(i * 16'h1111);
         req_valid = 1; rd_a = 3'(i); rd_b = 3'(7 - i); shift_in = 2'(i);
         tick();
         chk("stall op_valid", 16'(op_valid), 16'd1);
         chk("stall a_out", a_out, 16'hFFFF);
         chk("stall b_out", b_out, 16'b1111000011001111);
         chk("stall shift_out", 16'(shift_out), 16'd3);
      end
      wr_en = 0; req_valid = 0;
      finish_req("stall");

      // Write R4 on the READ_B edge: old value is read
      wr(3'd4, 16'h0000);
      req_valid = 1; rd_a = 3'd0; rd_b = 3'd4; shift_in = 2'd0;
      tick();
      req_valid = 0;
      tick();
      wr_en = 1; wr_num = 3'd4; wr_data = 16'h1234;
      tick();
      wr_en = 0;
      chk("collide op_valid", 16'(op_valid), 16'd1);
      chk("collide b_out old", b_out, 16'h0000);
      finish_req("collide");
      do_req("collide next", 3'd4, 3'd4, 2'd0, 16'h1234, 16'h1234);

      // Reset during READ_B aborts the request
      req_valid = 1; rd_a = 3'd2; rd_b = 3'd2; shift_in = 2'd3;
      tick();
      req_valid = 0;
      tick();
      reset_n = 0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (op_valid) bad++;
      end
      reset_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (op_valid) bad++;
      end
      chk("rst_abort op_valid pulses", 16'(bad), 16'd0);
      chk("rst_abort a_out", a_out, 16'h0);
      chk("rst_abort b_out", b_out, 16'h0);
      chk("rst_abort req_ready", 16'(req_ready), 16'd1);
      for (int i = 0; i < 4; i++)
         do_req($sformatf("rst_readback%0d", i), 3'(2 * i), 3'(2 * i + 1), 2'd0, 16'h0, 16'h0);

      // Back-to-back requests with req_valid and op_ready held high
      req_valid = 1; op_ready = 1; rd_a = 3'd0; rd_b = 3'd0; shift_in = 2'd0;
      acc = 0; ov = 0; bad = 0;
      for (int t = 1; t <= 16; t++) begin
         if (req_ready) acc++;
         tick();
         if (op_valid) ov++;
         if (op_valid != (t % 4 == 3)) bad++;
      end
      req_valid = 0; op_ready = 0;
      chk("b2b accepts", 16'(acc), 16'd4);
      chk("b2b op_valid cycles", 16'(ov), 16'd4);
      chk("b2b op_valid pattern", 16'(bad), 16'd0);
      tick();
      chk("b2b idle", 16'(req_ready), 16'd1);

      // Shifter fed from b_out/shift_out
      wr(3'd6, 16'hFFFF);
      for (int c = 0; c < 4; c++) begin
         start_req($sformatf("shift%0d", c), 3'd6, 3'd6, 2'(c));
         chk($sformatf("shift%0d result", c), shifter(b_out, shift_out), sexp[c]);
         finish_req($sformatf("shift%0d", c));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
